// File: rtl/md_pkg.sv
// -----------------------------------------------------------------------------
// md_pkg
//   Encodings and helpers shared by the D-stage decoder, the D/E pipeline
//   register and the E-stage multiply/divide unit (MDU).
//
//   MADop encoding (3 bits):
//     0 MD_NONE  no MDU operation
//     1 MULT     signed multiply, HI/LO result
//     2 MULTU    unsigned multiply
//     3 DIV      signed divide
//     4 DIVU     unsigned divide
//     5 MTHI     write HI (single cycle)
//     6 MTLO     write LO (single cycle)
//     7          reserved
// -----------------------------------------------------------------------------
package md_pkg;

    localparam int MADOP_W = 3;

    typedef enum logic [MADOP_W-1:0] {
        MD_NONE = 3'd0,
        MULT    = 3'd1,
        MULTU   = 3'd2,
        DIV     = 3'd3,
        DIVU    = 3'd4,
        MTHI    = 3'd5,
        MTLO    = 3'd6,
        MD_RSVD = 3'd7
    } madop_e;

    // True for the multi-cycle operations. On the cycle such an op sits in E
    // the MDU latches it, but its Busy output does not rise until the next
    // cycle, so this term covers that one-cycle gap. MTHI/MTLO complete in a
    // single cycle and never start a busy period.
    function automatic logic is_md_start(input logic [MADOP_W-1:0] op);
        logic res;
        res = 1'b0;
        case (op)
            MULT, MULTU, DIV, DIVU: res = 1'b1;
            default:                res = 1'b0;
        endcase
        return res;
    endfunction

endpackage : md_pkg

// File: rtl/md_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// md_hazard_ctrl
//   MDU structural-hazard detection for the D stage, merged with the generic
//   data-hazard stall, plus a saturating counter of MDU-induced stall cycles.
//
//   Ports:
//     clk, reset      clock, synchronous active-high reset
//     d_valid         D holds a real instruction
//     d_madop         MADop decoded in D
//     d_md_read       D is mfhi/mflo
//     e_valid         E holds a real instruction
//     e_madop         MADop currently presented to the MDU
//     md_busy         MDU Busy
//     data_stall_in   load-use / forwarding stall request
//     md_stall        stall caused by the MDU (combinational)
//     stall_d         freeze PC and F/D, bubble into E (combinational)
//     md_stall_cnt    saturating count of md_stall cycles
// -----------------------------------------------------------------------------
module md_hazard_ctrl
    import md_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               d_valid,
    input  logic [MADOP_W-1:0] d_madop,
    input  logic               d_md_read,
    input  logic               e_valid,
    input  logic [MADOP_W-1:0] e_madop,
    input  logic               md_busy,
    input  logic               data_stall_in,
    output logic               md_stall,
    output logic               stall_d,
    output logic [CNT_W-1:0]   md_stall_cnt
);

    logic             d_uses_md;
    logic             e_start;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_comb begin
        // MTHI/MTLO count as MDU users: the MDU ignores HI/LO writes while
        // busy, so they must wait just like mfhi/mflo and new mult/div.
        d_uses_md = d_valid & ((d_madop != MD_NONE) | d_md_read);
        e_start   = e_valid & is_md_start(e_madop);
        md_stall  = d_uses_md & (md_busy | e_start);
        stall_d   = md_stall | data_stall_in;
    end

    // Only MDU-caused cycles are counted; a cycle with both causes counts
    // once because md_stall is the sole increment condition.
    always_comb begin
        cnt_d = cnt_q;
        if (md_stall && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign md_stall_cnt = cnt_q;

endmodule : md_hazard_ctrl

// File: rtl/de_md_pipe_reg.sv
// -----------------------------------------------------------------------------
// de_md_pipe_reg
//   D/E pipeline register of the P6 pipelined MIPS core, feeding the E-stage
//   multiply/divide unit. When D must wait (MDU busy/starting, or a data
//   hazard) the D stage is frozen through stall_d and a bubble is loaded
//   into E; otherwise the D fields are copied into E.
//
//   Ports:
//     clk, reset                      clock, synchronous active-high reset
//     d_valid, d_instr, d_pc          D instruction, valid flag and PC
//     d_rs_val, d_rt_val, d_imm       forwarded operands, extended immediate
//     d_madop, d_md_read              MDU decode of the D instruction
//     data_stall_in                   stall request from the hazard unit
//     md_busy                         MDU Busy
//     stall_d                         freeze PC and F/D this cycle
//     e_valid, e_instr, e_pc          E instruction, valid flag and PC
//     e_rs_val, e_rt_val, e_imm       E operands
//     e_madop                         MADop presented to the MDU
//     md_stall_cnt                    cycles stalled because of the MDU
// -----------------------------------------------------------------------------
module de_md_pipe_reg
    import md_pkg::*;
#(
    parameter int W     = 32,
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               d_valid,
    input  logic [W-1:0]       d_instr,
    input  logic [W-1:0]       d_pc,
    input  logic [W-1:0]       d_rs_val,
    input  logic [W-1:0]       d_rt_val,
    input  logic [W-1:0]       d_imm,
    input  logic [MADOP_W-1:0] d_madop,
    input  logic               d_md_read,
    input  logic               data_stall_in,
    input  logic               md_busy,
    output logic               stall_d,
    output logic               e_valid,
    output logic [W-1:0]       e_instr,
    output logic [W-1:0]       e_pc,
    output logic [W-1:0]       e_rs_val,
    output logic [W-1:0]       e_rt_val,
    output logic [W-1:0]       e_imm,
    output logic [MADOP_W-1:0] e_madop,
    output logic [CNT_W-1:0]   md_stall_cnt
);

    logic               md_stall;

    logic               e_valid_q,  e_valid_d;
    logic [W-1:0]       e_instr_q,  e_instr_d;
    logic [W-1:0]       e_pc_q,     e_pc_d;
    logic [W-1:0]       e_rs_val_q, e_rs_val_d;
    logic [W-1:0]       e_rt_val_q, e_rt_val_d;
    logic [W-1:0]       e_imm_q,    e_imm_d;
    logic [MADOP_W-1:0] e_madop_q,  e_madop_d;

    md_hazard_ctrl #(
        .CNT_W (CNT_W)
    ) u_hazard (
        .clk           (clk),
        .reset         (reset),
        .d_valid       (d_valid),
        .d_madop       (d_madop),
        .d_md_read     (d_md_read),
        .e_valid       (e_valid_q),
        .e_madop       (e_madop_q),
        .md_busy       (md_busy),
        .data_stall_in (data_stall_in),
        .md_stall      (md_stall),
        .stall_d       (stall_d),
        .md_stall_cnt  (md_stall_cnt)
    );

    // Next E contents: an all-zero bubble while D is stalled, otherwise the
    // D fields. An invalid D slot never hands a real MADop to the MDU.
    always_comb begin
        e_valid_d  = d_valid;
        e_instr_d  = d_instr;
        e_pc_d     = d_pc;
        e_rs_val_d = d_rs_val;
        e_rt_val_d = d_rt_val;
        e_imm_d    = d_imm;
        e_madop_d  = d_valid ? d_madop : MD_NONE;
        if (stall_d) begin
            e_valid_d  = 1'b0;
            e_instr_d  = '0;
            e_pc_d     = '0;
            e_rs_val_d = '0;
            e_rt_val_d = '0;
            e_imm_d    = '0;
            e_madop_d  = MD_NONE;
        end
    end

    // ---- D/E boundary ----
    always_ff @(posedge clk) begin
        if (reset) begin
            e_valid_q  <= 1'b0;
            e_instr_q  <= '0;
            e_pc_q     <= '0;
            e_rs_val_q <= '0;
            e_rt_val_q <= '0;
            e_imm_q    <= '0;
            e_madop_q  <= MD_NONE;
        end else begin
            e_valid_q  <= e_valid_d;
            e_instr_q  <= e_instr_d;
            e_pc_q     <= e_pc_d;
            e_rs_val_q <= e_rs_val_d;
            e_rt_val_q <= e_rt_val_d;
            e_imm_q    <= e_imm_d;
            e_madop_q  <= e_madop_d;
        end
    end

    assign e_valid  = e_valid_q;
    assign e_instr  = e_instr_q;
    assign e_pc     = e_pc_q;
    assign e_rs_val = e_rs_val_q;
    assign e_rt_val = e_rt_val_q;
    assign e_imm    = e_imm_q;
    assign e_madop  = e_madop_q;

    // md_stall is consumed by the counter inside the hazard block; it is
    // kept as a named net here for debug visibility.
    logic unused_md_stall;
    assign unused_md_stall = md_stall;

endmodule : de_md_pipe_reg

// File: tb/tb_de_md_pipe_reg.sv
module tb_de_md_pipe_reg;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        d_valid;
    logic [31:0] d_instr, d_pc, d_rs_val, d_rt_val, d_imm;
    logic [2:0]  d_madop;
    logic        d_md_read;
    logic        data_stall_in;
    logic        md_busy;
    logic        stall_d;
    logic        e_valid;
    logic [31:0] e_instr, e_pc, e_rs_val, e_rt_val, e_imm;
    logic [2:0]  e_madop;
    logic [31:0] md_stall_cnt;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    de_md_pipe_reg #(.W(32), .CNT_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .d_valid       (d_valid),
        .d_instr       (d_instr),
        .d_pc          (d_pc),
        .d_rs_val      (d_rs_val),
        .d_rt_val      (d_rt_val),
        .d_imm         (d_imm),
        .d_madop       (d_madop),
        .d_md_read     (d_md_read),
        .data_stall_in (data_stall_in),
        .md_busy       (md_busy),
        .stall_d       (stall_d),
        .e_valid       (e_valid),
        .e_instr       (e_instr),
        .e_pc          (e_pc),
        .e_rs_val      (e_rs_val),
        .e_rt_val      (e_rt_val),
        .e_imm         (e_imm),
        .e_madop       (e_madop),
        .md_stall_cnt  (md_stall_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else n_pass++;
    endtask

    // Operand fields are derived from the PC so a copied field can be
    // predicted from the expected e_pc alone.
    task automatic drive_d(input logic v, input logic [31:0] pc, input logic [2:0] op, input logic rd);
        d_valid   = v;
        d_pc      = pc;
        d_instr   = pc ^ 32'hAAAA_0000;
        d_rs_val  = pc ^ 32'h0000_1111;
        d_rt_val  = pc ^ 32'h0000_2222;
        d_imm     = pc ^ 32'h0000_3333;
        d_madop   = op;
        d_md_read = rd;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [2:0]  op;
        logic        rd;
        logic        ds;
        logic        busy;
        logic        x_stall;
        logic        x_ev;
        logic [31:0] x_pc;
        logic [2:0]  x_op;
        logic [31:0] x_cnt;
    } vec_t;

    vec_t tbl[8];

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive_d(1'b1, 32'h0000_7000, 3'(MULT), 1'b0);
        data_stall_in = 1'b0;
        md_busy = 1'b0;
        edge_step();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // v, pc, op, rd, ds, busy | stall, e_valid, e_pc, e_madop, cnt
        tbl[0] = '{1'b1, 32'h3000, 3'(MD_NONE), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3000, 3'(MD_NONE), 32'd0}; // addu
        tbl[1] = '{1'b1, 32'h3004, 3'(MD_NONE), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3004, 3'(MD_NONE), 32'd0}; // ori
        tbl[2] = '{1'b1, 32'h3008, 3'(MULT),    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3008, 3'(MULT),    32'd0}; // mult
        tbl[3] = '{1'b1, 32'h300C, 3'(MD_NONE), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,    3'(MD_NONE), 32'd1}; // mfhi, e_start
        tbl[4] = '{1'b1, 32'h300C, 3'(MD_NONE), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,    3'(MD_NONE), 32'd2}; // mfhi, busy
        tbl[5] = '{1'b1, 32'h300C, 3'(MD_NONE), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h300C, 3'(MD_NONE), 32'd2}; // mfhi enters
        tbl[6] = '{1'b0, 32'h3010, 3'(MULT),    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h3010, 3'(MD_NONE), 32'd2}; // invalid D
        tbl[7] = '{1'b1, 32'h3014, 3'(MD_NONE), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,    3'(MD_NONE), 32'd2}; // data stall

        reset = 1'b1;
        drive_d(1'b0, 32'h0, 3'(MD_NONE), 1'b0);
        data_stall_in = 1'b0;
        md_busy = 1'b0;

        // Reset with live, non-stalling D inputs: reset must win.
        do_reset();
        chk("rst_e_valid", {31'd0, e_valid}, 32'd0);
        chk("rst_e_instr", e_instr, 32'd0);
        chk("rst_e_pc",    e_pc, 32'd0);
        chk("rst_e_rs",    e_rs_val, 32'd0);
        chk("rst_e_rt",    e_rt_val, 32'd0);
        chk("rst_e_imm",   e_imm, 32'd0);
        chk("rst_e_madop", {29'd0, e_madop}, 32'd0);
        chk("rst_cnt",     md_stall_cnt, 32'd0);

        // ---- table-driven sequence ----
        for (int i = 0; i < 8; i++) begin
            drive_d(tbl[i].v, tbl[i].pc, tbl[i].op, tbl[i].rd);
            data_stall_in = tbl[i].ds;
            md_busy = tbl[i].busy;
            #1;
            chk($sformatf("tbl%0d_stall", i), {31'd0, stall_d}, {31'd0, tbl[i].x_stall});
            edge_step();
            chk($sformatf("tbl%0d_e_valid", i), {31'd0, e_valid}, {31'd0, tbl[i].x_ev});
            chk($sformatf("tbl%0d_e_pc", i), e_pc, tbl[i].x_pc);
            chk($sformatf("tbl%0d_e_rs", i), e_rs_val,
                (tbl[i].x_pc == 32'd0) ? 32'd0 : (tbl[i].x_pc ^ 32'h0000_1111));
            chk($sformatf("tbl%0d_e_madop", i), {29'd0, e_madop}, {29'd0, tbl[i].x_op});
            chk($sformatf("tbl%0d_cnt", i), md_stall_cnt, tbl[i].x_cnt);
            @(negedge clk);
        end

        // ---- back-to-back MDU: mult then mfhi ----
        do_reset();
        drive_d(1'b1, 32'h0100, 3'(MULT), 1'b0);
        edge_step();
        chk("b2b_mult_in_e", {29'd0, e_madop}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive_d(1'b1, 32'h0104, 3'(MD_NONE), 1'b1);
            md_busy = (i > 0);
            #1;
            chk($sformatf("b2b_stall%0d", i), {31'd0, stall_d}, 32'd1);
            edge_step();
            chk($sformatf("b2b_bubble%0d", i), {31'd0, e_valid}, 32'd0);
        end
        @(negedge clk);
        md_busy = 1'b0;
        #1;
        chk("b2b_release", {31'd0, stall_d}, 32'd0);
        edge_step();
        chk("b2b_mfhi_valid", {31'd0, e_valid}, 32'd1);
        chk("b2b_mfhi_pc", e_pc, 32'h0104);
        chk("b2b_cnt", md_stall_cnt, 32'd6);

        // ---- independent ops while busy ----
        do_reset();
        drive_d(1'b1, 32'h0200, 3'(DIV), 1'b0);
        edge_step();
        @(negedge clk);
        md_busy = 1'b1;
        drive_d(1'b1, 32'h0204, 3'(MD_NONE), 1'b0);
        #1;
        chk("ind_addu_stall", {31'd0, stall_d}, 32'd0);
        edge_step();
        chk("ind_addu_pc", e_pc, 32'h0204);
        @(negedge clk);
        drive_d(1'b1, 32'h0208, 3'(MD_NONE), 1'b0);
        #1;
        chk("ind_subu_stall", {31'd0, stall_d}, 32'd0);
        edge_step();
        chk("ind_subu_pc", e_pc, 32'h0208);
        chk("ind_cnt", md_stall_cnt, 32'd0);

        // ---- mtlo while busy for 3 more cycles ----
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_d(1'b1, 32'h020C, 3'(MTLO), 1'b0);
            #1;
            chk($sformatf("mtlo_stall%0d", i), {31'd0, stall_d}, 32'd1);
            edge_step();
            chk($sformatf("mtlo_madop%0d", i), {29'd0, e_madop}, 32'd0);
        end
        @(negedge clk);
        md_busy = 1'b0;
        #1;
        chk("mtlo_release", {31'd0, stall_d}, 32'd0);
        edge_step();
        chk("mtlo_in_e", {29'd0, e_madop}, 32'd6);
        chk("mtlo_cnt", md_stall_cnt, 32'd3);
        // MTLO in E is not a start, so an mfhi behind it is not held.
        @(negedge clk);
        drive_d(1'b1, 32'h0210, 3'(MD_NONE), 1'b1);
        #1;
        chk("mtlo_no_start", {31'd0, stall_d}, 32'd0);
        edge_step();

        // ---- simultaneous stall causes ----
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_d(1'b1, 32'h0214, 3'(MD_NONE), 1'b1);
            data_stall_in = 1'b1;
            md_busy = (i < 2);
            #1;
            chk($sformatf("sim_stall%0d", i), {31'd0, stall_d}, 32'd1);
            edge_step();
            chk($sformatf("sim_bubble%0d", i), {31'd0, e_valid}, 32'd0);
        end
        chk("sim_cnt", md_stall_cnt, 32'd5);
        @(negedge clk);
        data_stall_in = 1'b0;
        edge_step();
        chk("sim_pass_pc", e_pc, 32'h0214);

        // ---- saturation, then reset mid-stall ----
        @(negedge clk);
        drive_d(1'b1, 32'h0300, 3'(MD_NONE), 1'b1);
        md_busy = 1'b1;
        force dut.u_hazard.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.u_hazard.cnt_q;
        for (int i = 0; i < 3; i++) begin
            edge_step();
            chk($sformatf("sat_cnt%0d", i), md_stall_cnt, 32'hFFFF_FFFF);
            @(negedge clk);
        end
        reset = 1'b1;
        #1;
        chk("rst_stall_comb", {31'd0, stall_d}, 32'd1);
        edge_step();
        chk("midrst_cnt", md_stall_cnt, 32'd0);
        chk("midrst_e_valid", {31'd0, e_valid}, 32'd0);
        chk("midrst_e_pc", e_pc, 32'd0);
        chk("midrst_e_madop", {29'd0, e_madop}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        md_busy = 1'b0;
        #1;
        chk("post_rst_stall", {31'd0, stall_d}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule : tb_de_md_pipe_reg

// File: doc/de_md_pipe_reg.md
Name: de_md_pipe_reg

Overview:
- D/E pipeline register for the P6 pipelined MIPS core, sitting directly upstream of the E-stage multiply/divide unit (MDU), which it feeds operands and MADop.
- Owns the MDU structural-hazard rule: freezes the D stage and injects an E-stage bubble while an MDU op is running or starting.
- Also honours the generic data-hazard stall and counts MDU-induced stall cycles.

Parameters:
- W, 32, datapath width (instr, pc, operands, imm).
- CNT_W, 32, width of the saturating MDU stall counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- d_valid  in  1  D holds a real instruction
- d_instr  in  W  D-stage instruction word
- d_pc  in  W  D-stage PC
- d_rs_val  in  W  forwarded GRF[rs]
- d_rt_val  in  W  forwarded GRF[rt]
- d_imm  in  W  extended immediate
- d_madop  in  3  MDU opcode decoded in D (package encoding)
- d_md_read  in  1  D is mfhi/mflo
- data_stall_in  in  1  stall request from the load-use/forwarding hazard unit
- md_busy  in  1  Busy output of the MDU
- stall_d  out  1  freeze PC and F/D register this cycle
- e_valid  out  1  E holds a real instruction
- e_instr, e_pc, e_rs_val, e_rt_val, e_imm  out  W each  registered copies
- e_madop  out  3  MADop presented to the MDU
- md_stall_cnt  out  CNT_W  cycles stalled because of the MDU

Behaviour:
- Reset: synchronous, active-high; clock clk. All e_* outputs are 0, e_madop = MD_NONE, e_valid = 0, md_stall_cnt = 0. Reset has priority over everything.
- d_uses_md = d_valid & (d_madop != MD_NONE | d_md_read).
- e_start = e_valid & e_madop in {MULT, MULTU, DIV, DIVU}. This covers the one cycle in which the MDU latches the op but Busy is not yet high.
- md_stall = d_uses_md & (md_busy | e_start).
- stall_d = md_stall | data_stall_in. This is combinational, with no added latency.
- Per clk edge, in priority order:
  - reset;
  - else if stall_d: load a bubble (e_valid = 0, e_madop = MD_NONE, all other e_* = 0);
  - else load the D fields, with e_valid = d_valid and e_madop = d_valid ? d_madop : MD_NONE.
- Invalid D (d_valid = 0) never stalls and never forwards a non-NONE MADop.
- Non-MDU instructions pass freely while md_busy = 1. The MDU runs in the background.
- MTHI/MTLO are treated as MDU ops. They stall while busy, because the MDU drops writes while busy.
- MTHI/MTLO in E do not set e_start (single-cycle write).
- md_stall_cnt increments by 1 on each clk where md_stall = 1 and reset = 0. It saturates at all-ones and does not wrap.
  - Cycles stalled only by data_stall_in are not counted.
  - When both stall causes are true in the same cycle, the cycle counts once.
- Reset mid-operation (reset while stalled or MDU busy) clears E and the counter on that edge. stall_d then follows inputs combinationally.
- A bubble inserted in cycle N means e_valid = 0 in cycle N+1. The held D instruction enters E on the first edge where stall_d = 0.

Decomposition:
- Shared package md_pkg:
  - MADop encoding: MD_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, 7 reserved.
  - is_md_start(op) function.
  - This is the same encoding the MDU and decoder use.
- One sub-module, md_hazard_ctrl: combinational md_stall/stall_d plus the saturating counter register.
- The top level holds the E-register fields.

Test Plan:
- Plain flow: addu at pc 0x3000, then ori at 0x3004, md_busy = 0, data_stall_in = 0 -> stall_d = 0 always; e_pc = 0x3000 then 0x3004 on successive edges; md_stall_cnt stays 0.
- Back-to-back MDU: mult (E) then mfhi (D); bench drives md_busy high for 5 cycles starting the cycle after mult reaches E -> stall_d high for 6 cycles (1 e_start + 5 busy); E shows 6 bubbles; mfhi enters E on cycle 7; md_stall_cnt = 6.
- Independent op during busy: div in E, then addu/subu in D with md_busy = 1 for 10 cycles -> no stalls; both pass; md_stall_cnt = 0.
- mtlo while busy (md_busy = 1 for 3 more cycles) -> stall_d = 1 for 3 cycles; e_madop is MD_NONE during the stall, then MTLO = 6 in the cycle after busy drops.
- Simultaneous causes: data_stall_in = 1 and md_stall = 1 for 2 cycles, then data_stall_in alone for 1 cycle -> 3 bubbles; md_stall_cnt += 2.
- Saturation and reset: preload the counter via forced state to 0xFFFFFFFE, stall 3 cycles -> reads 0xFFFFFFFF. Assert reset mid-stall -> next cycle all e_* = 0 and md_stall_cnt = 0.
